// File: rtl/mmp_pkg.sv
// Shared types and width helpers for the variable-length word-serial Montgomery multiplier.
package mmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QCALC,
        ST_ROW,
        ST_TOP,
        ST_SUB,
        ST_OUT
    } state_t;

    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

    // t = a + x*y + m*q + c never exceeds 2K+2 bits, so its carry fits in K+2.
    function automatic int t_width(input int k);
        return 2 * k + 2;
    endfunction

    function automatic int c_width(input int k);
        return k + 2;
    endfunction

endpackage

// File: rtl/mmp_var_mac.sv
// One word step of the Montgomery row: t = a + x*y + m*q + c, split into low word and carry.
module mmp_var_mac
    import mmp_pkg::*;
#(
    parameter int K           = 128,
    parameter int MULT_METHOD = 0
) (
    input  logic [K-1:0]          a,
    input  logic [K-1:0]          x,
    input  logic [K-1:0]          y,
    input  logic [K-1:0]          m,
    input  logic [K-1:0]          q,
    input  logic [c_width(K)-1:0] c,
    output logic [K-1:0]          t_lo,
    output logic [c_width(K)-1:0] t_hi
);

    localparam int TW = t_width(K);

    logic [TW-1:0] t;

    // Only the flat combinational form exists today; other methods slot in here.
    generate
        if (MULT_METHOD == 0) begin : g_comb
            assign t = TW'(a) + TW'(x) * TW'(y) + TW'(m) * TW'(q) + TW'(c);
        end else begin : g_alt
            assign t = (TW'(x) * TW'(y) + TW'(c)) + (TW'(m) * TW'(q) + TW'(a));
        end
    endgenerate

    assign t_lo = t[K-1:0];
    assign t_hi = t[TW-1:K];

endmodule

// File: rtl/mmp_iddmm_var.sv
// Word-serial Montgomery multiplier, res = x*y*R^-1 mod m, with run-time length and streamed output.
module mmp_iddmm_var
    import mmp_pkg::*;
#(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N),
    parameter int LEN_W  = len_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [2:0]        wr_ena,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [K-1:0]      wr_x,
    input  logic [K-1:0]      wr_y,
    input  logic [K-1:0]      wr_m,
    input  logic [K-1:0]      wr_m1,
    input  logic              task_req,
    output logic              task_busy,
    output logic              task_err,
    output logic              task_grant,
    output logic [K-1:0]      task_res,
    output logic              task_end
);

    localparam int CW = c_width(K);

    logic [K-1:0]      x_mem [N];
    logic [K-1:0]      y_mem [N];
    logic [K-1:0]      m_mem [N];
    logic [K-1:0]      a_mem [N];
    logic [K-1:0]      d_mem [N];
    logic [K-1:0]      m1_r;
    logic [K-1:0]      q_r;
    logic [1:0]        a_top;
    logic [CW-1:0]     c_r;
    logic              b_r;
    logic              use_d;
    logic [LEN_W-1:0]  len_r;
    logic [ADDR_W-1:0] i_r;
    logic [ADDR_W-1:0] j_r;
    state_t            state;

    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            if (wr_ena[0]) x_mem[wr_addr] <= wr_x;
            if (wr_ena[1]) y_mem[wr_addr] <= wr_y;
            if (wr_ena[2]) begin
                m_mem[wr_addr] <= wr_m;
                m1_r           <= wr_m1;
            end
        end
    end

    // Row 0 sees an all-zero accumulator, so a[] never needs an explicit clear pass.
    logic          zero_rd;
    logic [K-1:0]  a_rd;
    logic [1:0]    a_top_rd;
    logic [K-1:0]  mac_q;
    logic [CW-1:0] mac_c;
    logic [K-1:0]  t_lo;
    logic [CW-1:0] t_hi;
    logic [K-1:0]  q_calc;
    logic [CW-1:0] top_sum;
    logic [K:0]    diff;
    logic          sel_d;
    logic [K-1:0]  word0;
    logic [K-1:0]  next_word;
    logic          last_j;
    logic          last_i;

    assign zero_rd  = (i_r == '0) && (state == ST_QCALC || state == ST_ROW || state == ST_TOP);
    assign a_rd     = zero_rd ? '0 : a_mem[j_r];
    assign a_top_rd = zero_rd ? 2'b00 : a_top;
    assign mac_q    = (state == ST_ROW) ? q_r : '0;
    assign mac_c    = (state == ST_ROW) ? c_r : '0;

    mmp_var_mac #(.K(K), .MULT_METHOD(0)) u_mac (
        .a    (a_rd),
        .x    (x_mem[j_r]),
        .y    (y_mem[i_r]),
        .m    (m_mem[j_r]),
        .q    (mac_q),
        .c    (mac_c),
        .t_lo (t_lo),
        .t_hi (t_hi)
    );

    assign q_calc  = t_lo * m1_r;
    assign top_sum = CW'(a_top_rd) + c_r;
    assign diff    = {1'b0, a_mem[j_r]} - {1'b0, m_mem[j_r]} - {{K{1'b0}}, b_r};
    assign last_j  = (LEN_W'(j_r) == len_r - LEN_W'(1));
    assign last_i  = (LEN_W'(i_r) == len_r - LEN_W'(1));
    // Keep the difference when the accumulator overflowed or a >= m.
    assign sel_d   = (a_top != 2'b00) || !diff[K];
    assign word0   = sel_d ? ((len_r == LEN_W'(1)) ? diff[K-1:0] : d_mem[0]) : a_mem[0];
    assign next_word = use_d ? d_mem[ADDR_W'(j_r + 1'b1)] : a_mem[ADDR_W'(j_r + 1'b1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            task_busy  <= 1'b0;
            task_err   <= 1'b0;
            task_grant <= 1'b0;
            task_res   <= '0;
            task_end   <= 1'b0;
            len_r      <= '0;
            i_r        <= '0;
            j_r        <= '0;
            q_r        <= '0;
            c_r        <= '0;
            b_r        <= 1'b0;
            a_top      <= 2'b00;
            use_d      <= 1'b0;
        end else begin
            task_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (task_req) begin
                        if (cfg_len == '0 || cfg_len > LEN_W'(N)) begin
                            task_err <= 1'b1;
                        end else begin
                            len_r     <= cfg_len;
                            i_r       <= '0;
                            j_r       <= '0;
                            task_busy <= 1'b1;
                            state     <= ST_QCALC;
                        end
                    end
                end
                ST_QCALC: begin
                    q_r   <= q_calc;
                    j_r   <= '0;
                    c_r   <= '0;
                    state <= ST_ROW;
                end
                ST_ROW: begin
                    if (j_r != '0) a_mem[j_r - 1'b1] <= t_lo;
                    c_r <= t_hi;
                    if (last_j) begin
                        j_r   <= '0;
                        state <= ST_TOP;
                    end else begin
                        j_r <= j_r + 1'b1;
                    end
                end
                ST_TOP: begin
                    a_mem[ADDR_W'(len_r - LEN_W'(1))] <= top_sum[K-1:0];
                    a_top <= top_sum[K+1:K];
                    if (last_i) begin
                        b_r   <= 1'b0;
                        j_r   <= '0;
                        state <= ST_SUB;
                    end else begin
                        i_r   <= i_r + 1'b1;
                        state <= ST_QCALC;
                    end
                end
                ST_SUB: begin
                    d_mem[j_r] <= diff[K-1:0];
                    b_r        <= diff[K];
                    if (last_j) begin
                        use_d      <= sel_d;
                        task_grant <= 1'b1;
                        task_res   <= word0;
                        task_end   <= (len_r == LEN_W'(1));
                        j_r        <= '0;
                        state      <= ST_OUT;
                    end else begin
                        j_r <= j_r + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (last_j) begin
                        task_grant <= 1'b0;
                        task_end   <= 1'b0;
                        task_res   <= '0;
                        task_busy  <= 1'b0;
                        i_r        <= '0;
                        j_r        <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        task_res <= next_word;
                        task_end <= (LEN_W'(j_r) + LEN_W'(2) == len_r);
                        j_r      <= j_r + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmp_iddmm_var.sv
// Directed bench for mmp_iddmm_var at K=16, N=4 with hand-computed Montgomery products.
module tb_mmp_iddmm_var;

    localparam int K      = 16;
    localparam int N      = 4;
    localparam int ADDR_W = $clog2(N);
    localparam int LEN_W  = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [LEN_W-1:0]  cfg_len;
    logic [2:0]        wr_ena;
    logic [ADDR_W-1:0] wr_addr;
    logic [K-1:0]      wr_x, wr_y, wr_m, wr_m1;
    logic              task_req;
    logic              task_busy, task_err, task_grant, task_end;
    logic [K-1:0]      task_res;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [K-1:0] exp_q[$];

    mmp_iddmm_var #(.K(K), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_len    (cfg_len),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_m       (wr_m),
        .wr_m1      (wr_m1),
        .task_req   (task_req),
        .task_busy  (task_busy),
        .task_err   (task_err),
        .task_grant (task_grant),
        .task_res   (task_res),
        .task_end   (task_end)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic write_word(input int addr, input logic [K-1:0] x, input logic [K-1:0] y,
                              input logic [K-1:0] m, input logic [K-1:0] m1);
        wr_ena  = 3'b111;
        wr_addr = addr[ADDR_W-1:0];
        wr_x    = x;
        wr_y    = y;
        wr_m    = m;
        wr_m1   = m1;
        @(posedge clk); #1;
        wr_ena  = 3'b000;
    endtask

    task automatic check_idle_outputs(input string name);
        tests_run++;
        if ({task_busy, task_err, task_grant, task_end} !== 4'b0000 || task_res !== '0) begin
            tests_failed++;
            $display("FAIL %s: busy/err/grant/end=%b res=%h, required 0000 res=0000", name,
                     {task_busy, task_err, task_grant, task_end}, task_res);
        end
    endtask

    task automatic run_task(input int len, input int exp_first, input bit inject, input string name);
        int  cyc = 0;
        int  first = -1;
        int  busy_cnt = 0;
        bit  done = 0;
        int  exp_busy = len * (len + 4);
        logic [K-1:0] exp_w;
        cfg_len  = len[LEN_W-1:0];
        task_req = 1'b1;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            task_req = 1'b0;
            wr_ena   = 3'b000;
            cyc++;
            if (inject && cyc == 3) begin
                task_req = 1'b1;
                wr_ena   = 3'b111;
                wr_addr  = '0;
                wr_x     = 16'hAAAA;
                wr_y     = 16'h5555;
                wr_m     = 16'h1235;
                wr_m1    = 16'h0F0F;
            end
            @(negedge clk);
            if (task_busy) busy_cnt++;
            if (task_err) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s err: task_err=1 in cycle %0d, required 0", name, cyc);
            end
            if (task_grant) begin
                if (first < 0) first = cyc;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s word: extra word %h in cycle %0d, required none", name, task_res, cyc);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (task_res !== exp_w) begin
                        tests_failed++;
                        $display("FAIL %s word: got %h, required %h", name, task_res, exp_w);
                    end
                end
                if (task_end) done = 1;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s timeout: no task_end within %0d cycles, required end", name, cyc);
        end
        tests_run++;
        if (first != exp_first) begin
            tests_failed++;
            $display("FAIL %s latency: first grant cycle %0d, required %0d", name, first, exp_first);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s count: %0d words missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tests_run++;
        if (busy_cnt != exp_busy) begin
            tests_failed++;
            $display("FAIL %s busy: %0d busy cycles, required %0d", name, busy_cnt, exp_busy);
        end
        @(posedge clk); #1;
        check_idle_outputs({name, " after"});
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_len = '0; wr_ena = '0; wr_addr = '0;
        wr_x = '0; wr_y = '0; wr_m = '0; wr_m1 = '0; task_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");
    endtask

    task automatic test_len1_basic();
        write_word(0, 16'h000F, 16'h0005, 16'hFFF1, 16'hEEEF);
        exp_q.push_back(16'h0005);
        run_task(1, 5, 0, "len1_basic");
    endtask

    task automatic test_len1_sub();
        write_word(0, 16'hFFF0, 16'h000F, 16'hFFF1, 16'hEEEF);
        exp_q.push_back(16'hFFF0);
        run_task(1, 5, 0, "len1_sub");
    endtask

    task automatic test_len2();
        write_word(0, 16'h0005, 16'h0007, 16'hFFFB, 16'hCCCD);
        write_word(1, 16'h0000, 16'h0000, 16'hFFFF, 16'hCCCD);
        exp_q.push_back(16'h0007);
        exp_q.push_back(16'h0000);
        run_task(2, 11, 0, "len2");
    endtask

    task automatic test_busy_ignore();
        exp_q.push_back(16'h0007);
        exp_q.push_back(16'h0000);
        run_task(2, 11, 1, "busy_ignore");
        exp_q.push_back(16'h0007);
        exp_q.push_back(16'h0000);
        run_task(2, 11, 0, "busy_ignore_rerun");
    endtask

    task automatic test_bad_len();
        int lens[2] = '{0, 5};
        foreach (lens[k]) begin
            cfg_len  = lens[k][LEN_W-1:0];
            task_req = 1'b1;
            @(posedge clk); #1;
            task_req = 1'b0;
            tests_run++;
            if (task_err !== 1'b1 || task_busy !== 1'b0 || task_grant !== 1'b0) begin
                tests_failed++;
                $display("FAIL bad_len%0d: err/busy/grant=%b%b%b, required 100", lens[k],
                         task_err, task_busy, task_grant);
            end
            @(posedge clk); #1;
            check_idle_outputs("bad_len_after");
        end
    endtask

    task automatic test_len4_zero();
        write_word(0, 16'h0000, 16'h0000, 16'hFFF1, 16'hEEEF);
        for (int a = 1; a < 4; a++) write_word(a, 16'h0000, 16'h0000, 16'hFFFF, 16'hEEEF);
        repeat (4) exp_q.push_back(16'h0000);
        run_task(4, 29, 0, "len4_zero");
    endtask

    task automatic test_reset_mid();
        write_word(0, 16'h000F, 16'h0005, 16'hFFF1, 16'hEEEF);
        cfg_len  = 1;
        task_req = 1'b1;
        @(posedge clk); #1;
        task_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("reset_mid");
        exp_q.push_back(16'h0005);
        run_task(1, 5, 0, "reset_rerun");
    endtask

    initial begin
        test_reset();
        test_len1_basic();
        test_len1_sub();
        test_len2();
        test_busy_ignore();
        test_bad_len();
        test_len4_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
